// File: rtl/eim_pkg.sv
// Shared types and widths for the EIM burst transaction engine.
package eim_pkg;

  localparam int unsigned EIM_ADDR_W = 19;
  localparam int unsigned EIM_WORD_W = 18;
  localparam int unsigned EIM_DATA_W = 16;
  localparam int unsigned EIM_HI_W   = 3;
  localparam int unsigned EIM_DLY_W  = 8;
  localparam int unsigned EIM_BEAT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    HOLD
  } eim_state_e;

  typedef struct packed {
    logic [EIM_WORD_W-1:0] addr;
    logic [EIM_DATA_W-1:0] data;
  } eim_wr_t;

  // Byte address {hi, lo} reduced to a word address; byte lane bit dropped.
  function automatic logic [EIM_WORD_W-1:0] eim_word_addr(
    input logic [EIM_HI_W-1:0]   hi,
    input logic [EIM_DATA_W-1:0] lo
  );
    return {hi, lo[EIM_DATA_W-1:1]};
  endfunction

endpackage

// File: rtl/eim_beat_timer.sv
// Delay/beat counter pair: waits dly edges after load, then fires one beat per
// edge until BURST_LEN beats have fired.
module eim_beat_timer
  import eim_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  run,
  input  logic [EIM_DLY_W-1:0]  dly,
  output logic                  fire_c,
  output logic                  last_c,
  output logic [EIM_BEAT_W-1:0] beat_c,
  output logic                  done
);

  logic [EIM_DLY_W-1:0]  dly_q;
  logic [EIM_BEAT_W-1:0] beat_q;

  // A zero delay fires beat 0 on the load edge itself.
  always_comb begin
    fire_c = 1'b0;
    beat_c = beat_q;
    if (load) begin
      beat_c = '0;
      fire_c = (dly == '0);
    end else if (run && !done) begin
      fire_c = (dly_q >= dly);
    end
    last_c = fire_c && (beat_c == EIM_BEAT_W'(BURST_LEN - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_q  <= '0;
      beat_q <= '0;
      done   <= 1'b0;
    end else if (load) begin
      dly_q  <= EIM_DLY_W'(1);
      beat_q <= fire_c ? EIM_BEAT_W'(1) : '0;
      done   <= last_c;
    end else if (run) begin
      if (dly_q < dly) dly_q <= dly_q + EIM_DLY_W'(1);
      if (fire_c)      beat_q <= beat_q + EIM_BEAT_W'(1);
      if (last_c)      done <= 1'b1;
    end
  end

endmodule

// File: rtl/eim_burst_ctrl.sv
// EIM burst engine: turns sampled bus cycles into word-addressed register-file
// write strobes and read requests, and returns read data on ad_out.
module eim_burst_ctrl
  import eim_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned WR_DLY    = 1,
  parameter int unsigned RD_DLY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_n,
  input  logic                  lba_n,
  input  logic                  rw,
  input  logic [EIM_HI_W-1:0]   hi_addr,
  input  logic [EIM_DATA_W-1:0] ad_in,
  output logic [EIM_DATA_W-1:0] ad_out,
  output logic                  ad_oe,
  output logic                  wr_en,
  output logic [EIM_WORD_W-1:0] wr_addr,
  output logic [EIM_DATA_W-1:0] wr_data,
  output logic                  rd_en,
  output logic [EIM_WORD_W-1:0] rd_addr,
  input  logic [EIM_DATA_W-1:0] rd_data,
  output logic                  busy
);

  eim_state_e            state_q, state_d;
  logic [EIM_WORD_W-1:0] base_q, base_d;
  eim_wr_t               wr_q, wr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [EIM_WORD_W-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [EIM_DATA_W-1:0] ad_out_q, ad_out_d;
  logic                  ad_oe_q, ad_oe_d;
  logic                  busy_q;

  logic                  e0;
  logic                  run;
  logic                  rd_mode;
  logic [EIM_DLY_W-1:0]  tmr_dly;
  logic [EIM_WORD_W-1:0] new_base;
  logic [EIM_WORD_W-1:0] beat_addr;
  logic                  fire_c;
  logic                  last_c;
  logic [EIM_BEAT_W-1:0] beat_c;
  logic                  tmr_done;

  // Address edge (fresh or restart), timer run enable and per-beat address.
  always_comb begin
    e0        = !cs_n && !lba_n;
    run       = !cs_n && lba_n && ((state_q == WRITE) || (state_q == READ));
    rd_mode   = e0 ? rw : (state_q == READ);
    tmr_dly   = rd_mode ? EIM_DLY_W'(RD_DLY - 2) : EIM_DLY_W'(WR_DLY);
    new_base  = eim_word_addr(hi_addr, ad_in);
    beat_addr = (e0 ? new_base : base_q) + EIM_WORD_W'(beat_c);
  end

  eim_beat_timer #(
    .BURST_LEN (BURST_LEN)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (e0),
    .run    (run),
    .dly    (tmr_dly),
    .fire_c (fire_c),
    .last_c (last_c),
    .beat_c (beat_c),
    .done   (tmr_done)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wr_d      = wr_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_pend_d = 1'b0;
    ad_out_d  = ad_out_q;
    ad_oe_d   = 1'b0;

    if (cs_n) begin
      state_d = IDLE;
    end else if (!lba_n) begin
      state_d = rw ? READ : WRITE;
      base_d  = new_base;
    end else begin
      case (state_q)
        WRITE: if (last_c) state_d = HOLD;
        // Stay until the last captured beat has had its full cycle on ad_out.
        READ:  if (tmr_done && !rd_en_q && !rd_pend_q) state_d = HOLD;
        default: state_d = state_q;
      endcase
    end

    if (fire_c) begin
      if (rd_mode) begin
        rd_en_d   = 1'b1;
        rd_addr_d = beat_addr;
      end else begin
        wr_en_d   = 1'b1;
        wr_d.addr = beat_addr;
        wr_d.data = ad_in;
      end
    end

    // rd_data is valid the cycle after rd_en, so capture lags issue by two edges.
    if (run && (state_q == READ)) begin
      rd_pend_d = rd_en_q;
      ad_oe_d   = rd_en_q || rd_pend_q;
      if (rd_pend_q) ad_out_d = rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      wr_q      <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wr_q      <= wr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= rd_pend_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_eim_burst_ctrl.sv
// Directed bench for eim_burst_ctrl (BURST_LEN=4, WR_DLY=1, RD_DLY=2).
module tb_eim_burst_ctrl;

  logic        clk;
  logic        reset;
  logic        cs_n;
  logic        lba_n;
  logic        rw;
  logic [2:0]  hi_addr;
  logic [15:0] ad_in;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [15:0] rd_data;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  eim_burst_ctrl #(
    .BURST_LEN (4),
    .WR_DLY    (1),
    .RD_DLY    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_n    (cs_n),
    .lba_n   (lba_n),
    .rw      (rw),
    .hi_addr (hi_addr),
    .ad_in   (ad_in),
    .ad_out  (ad_out),
    .ad_oe   (ad_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: read data is ~address, valid the cycle after rd_en.
  initial rd_data = 16'h0000;
  always @(posedge clk) if (rd_en) rd_data <= ~rd_addr[15:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!reset) check("wr_rd_excl", 32'(wr_en & rd_en), 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cs_n = 1'b1; lba_n = 1'b1; rw = 1'b0; hi_addr = 3'd0; ad_in = 16'h0000;
  endtask

  task automatic addr_phase(input logic r, input logic [18:0] byte_addr);
    cs_n = 1'b0; lba_n = 1'b0; rw = r;
    hi_addr = byte_addr[18:16]; ad_in = byte_addr[15:0];
    tick();
    lba_n = 1'b1;
  endtask

  task automatic end_cycle();
    cs_n = 1'b1; lba_n = 1'b1;
    tick();
    check("end_busy", 32'(busy), 32'd0);
  endtask

  logic [17:0] wb_addr [4] = '{18'h07FFE, 18'h07FFF, 18'h08000, 18'h08001};
  logic        r_en    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [17:0] r_addr  [4] = '{18'h00100, 18'h00101, 18'h00102, 18'h00103};
  logic        r_oe    [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] r_out   [7] = '{16'h0, 16'h0, 16'hFEFF, 16'hFEFE, 16'hFEFD, 16'hFEFC, 16'hFEFC};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_idle();
    tick(); tick();
    check("rst_ad_out", 32'(ad_out), 32'd0);
    check("rst_ad_oe", 32'(ad_oe), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #3 reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single write
    addr_phase(1'b0, 19'h10010);
    check("sw_e0_busy", 32'(busy), 32'd1);
    check("sw_e0_wr_en", 32'(wr_en), 32'd0);
    ad_in = 16'hA5A5;
    tick();
    check("sw_wr_en", 32'(wr_en), 32'd1);
    check("sw_wr_addr", 32'(wr_addr), 32'h08008);
    check("sw_wr_data", 32'(wr_data), 32'hA5A5);
    check("sw_rd_en", 32'(rd_en), 32'd0);
    end_cycle();
    check("sw_wr_en_off", 32'(wr_en), 32'd0);

    // 4-beat write burst then HOLD
    addr_phase(1'b0, 19'h0FFFC);
    for (int k = 0; k < 4; k++) begin
      ad_in = 16'(k + 1);
      tick();
      check("wb_wr_en", 32'(wr_en), 32'd1);
      check("wb_wr_addr", 32'(wr_addr), 32'(wb_addr[k]));
      check("wb_wr_data", 32'(wr_data), 32'(k + 1));
    end
    ad_in = 16'h0005;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("wb_hold_wr_en", 32'(wr_en), 32'd0);
      check("wb_hold_busy", 32'(busy), 32'd1);
    end
    end_cycle();

    // 4-beat read, base word 0x100
    addr_phase(1'b1, 19'h00200);
    for (int e = 0; e < 7; e++) begin
      if (e > 0) tick();
      check("rd_rd_en", 32'(rd_en), 32'(r_en[e]));
      if (e < 4) check("rd_rd_addr", 32'(rd_addr), 32'(r_addr[e]));
      check("rd_ad_oe", 32'(ad_oe), 32'(r_oe[e]));
      if (e >= 2) check("rd_ad_out", 32'(ad_out), 32'(r_out[e]));
      check("rd_wr_en", 32'(wr_en), 32'd0);
    end
    check("rd_hold_busy", 32'(busy), 32'd1);
    end_cycle();

    // Abort a read at E(RD_DLY)
    addr_phase(1'b1, 19'h00400);
    check("ab_e0_rd_addr", 32'(rd_addr), 32'h00200);
    tick();
    check("ab_e1_rd_addr", 32'(rd_addr), 32'h00201);
    check("ab_e1_ad_oe", 32'(ad_oe), 32'd1);
    cs_n = 1'b1;
    tick();
    check("ab_rd_en", 32'(rd_en), 32'd0);
    check("ab_ad_oe", 32'(ad_oe), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    tick();
    check("ab_rd_en2", 32'(rd_en), 32'd0);

    // Restart: write interrupted at beat 2 by a read address edge
    addr_phase(1'b0, 19'h00020);
    ad_in = 16'h1111;
    tick();
    check("rs_wr0_addr", 32'(wr_addr), 32'h00010);
    ad_in = 16'h2222;
    tick();
    check("rs_wr1_en", 32'(wr_en), 32'd1);
    check("rs_wr1_addr", 32'(wr_addr), 32'h00011);
    addr_phase(1'b1, 19'h40100);
    check("rs_wr_stop", 32'(wr_en), 32'd0);
    check("rs_rd_en", 32'(rd_en), 32'd1);
    check("rs_rd_addr", 32'(rd_addr), 32'h20080);
    tick();
    check("rs_rd_addr1", 32'(rd_addr), 32'h20081);
    check("rs_ad_oe", 32'(ad_oe), 32'd1);
    check("rs_wr_en1", 32'(wr_en), 32'd0);
    tick();
    check("rs_ad_out", 32'(ad_out), 32'hFF7F);
    end_cycle();

    // Word address wraps modulo 2^18
    addr_phase(1'b0, 19'h7FFFE);
    ad_in = 16'hBEEF;
    tick();
    check("wr_wrap_addr0", 32'(wr_addr), 32'h3FFFF);
    check("wr_wrap_data0", 32'(wr_data), 32'hBEEF);
    ad_in = 16'hCAFE;
    tick();
    check("wr_wrap_addr1", 32'(wr_addr), 32'h00000);
    check("wr_wrap_data1", 32'(wr_data), 32'hCAFE);
    end_cycle();

    // Asynchronous reset mid-read, then a normal read
    addr_phase(1'b1, 19'h00600);
    tick(); tick();
    check("ar_ad_out", 32'(ad_out), 32'hFCFF);
    #3 reset = 1'b1;
    #1;
    check("ar_ad_oe", 32'(ad_oe), 32'd0);
    check("ar_ad_out0", 32'(ad_out), 32'd0);
    check("ar_rd_en", 32'(rd_en), 32'd0);
    check("ar_rd_addr", 32'(rd_addr), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    bus_idle();
    #1 reset = 1'b0;
    tick();
    check("ar_idle_rd_en", 32'(rd_en), 32'd0);
    addr_phase(1'b1, 19'h00800);
    check("ar_new_rd_en", 32'(rd_en), 32'd1);
    check("ar_new_rd_addr", 32'(rd_addr), 32'h00400);
    tick();
    check("ar_new_rd_addr1", 32'(rd_addr), 32'h00401);
    check("ar_new_ad_oe", 32'(ad_oe), 32'd1);
    end_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
